// File: rtl/titan_pipe_reg.sv
// Elastic valid/ready pipeline stage with optional 2-entry skid buffer, synchronous flush
// and a saturating backpressure-cycle counter.
module titan_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              stall_cnt_clr_i
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StBoth  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept, emit;

  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = main_q;
  assign stall_cnt_o = stall_q;

  // Skid mode derives ready from registered state only, cutting the ready path.
  if (SKID != 0) begin : g_skid_ready
    assign in_ready_o = (state_q != StBoth);
  end else begin : g_comb_ready
    assign in_ready_o = !out_valid_o || out_ready_i;
  end

  assign accept = in_valid_i && in_ready_o;
  assign emit   = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
          main_d  = in_data_i;
        end
      end
      StFull: begin
        if (accept && emit) begin
          main_d = in_data_i;
        end else if (accept && (SKID != 0)) begin
          state_d = StBoth;
          skid_d  = in_data_i;
        end else if (emit) begin
          state_d = StEmpty;
        end
      end
      StBoth: begin
        if (emit) begin
          state_d = StFull;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush kills held beats and any same-cycle accept; data registers are don't-care when empty.
    if (flush_i) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_cnt_clr_i) begin
      stall_d = '0;
    end else if (out_valid_o && !out_ready_i && (stall_q != CntMax)) begin
      stall_d = stall_q + CntOne;
    end
  end

  always_comb begin
    occupancy_o = 2'd0;
    case (state_q)
      StFull:  occupancy_o = 2'd1;
      StBoth:  occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_titan_pipe_reg.sv
// Bench for titan_pipe_reg: a skid instance (32-bit) and a non-skid instance (8-bit, CNT_W=2),
// directed vector table, hand sequences and randomized queue-model checking.
module tb_titan_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Skid instance signals
  logic        s_flush = 0, s_iv = 0, s_irdy, s_ov, s_ordy = 0, s_clr = 0;
  logic [31:0] s_id = 0, s_od;
  logic [1:0]  s_occ;
  logic [15:0] s_stall;

  // Non-skid instance signals
  logic        n_flush = 0, n_iv = 0, n_irdy, n_ov, n_ordy = 0, n_clr = 0;
  logic [7:0]  n_id = 0, n_od;
  logic [1:0]  n_occ;
  logic [1:0]  n_stall;

  titan_pipe_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) u_skid (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (s_flush),
    .in_valid_i     (s_iv),
    .in_ready_o     (s_irdy),
    .in_data_i      (s_id),
    .out_valid_o    (s_ov),
    .out_ready_i    (s_ordy),
    .out_data_o     (s_od),
    .occupancy_o    (s_occ),
    .stall_cnt_o    (s_stall),
    .stall_cnt_clr_i(s_clr)
  );

  titan_pipe_reg #(.DATA_W(8), .SKID(0), .CNT_W(2)) u_nskid (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (n_flush),
    .in_valid_i     (n_iv),
    .in_ready_o     (n_irdy),
    .in_data_i      (n_id),
    .out_valid_o    (n_ov),
    .out_ready_i    (n_ordy),
    .out_data_o     (n_od),
    .occupancy_o    (n_occ),
    .stall_cnt_o    (n_stall),
    .stall_cnt_clr_i(n_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        flush;
    logic        clr;
    logic        ov;
    logic [31:0] od;
    logic        irdy;
    logic [1:0]  occ;
    logic [15:0] stall;
  } vec_t;

  vec_t tbl[13];

  logic [31:0] sq[$];
  logic [7:0]  nq[$];
  int unsigned s_stall_m, n_stall_m;
  logic        s_rdy_m, n_rdy_m, s_acc, s_em, n_acc, n_em;

  initial begin
    // Expected outputs are the values seen just before the edge that applies the inputs.
    tbl[0]  = '{1'b1, 32'hA, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 16'd0};
    tbl[1]  = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 2'd1, 16'd0};
    tbl[2]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2, 16'd1};
    tbl[3]  = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2, 16'd2};
    tbl[4]  = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 1'b1, 2'd1, 16'd2};
    tbl[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC, 1'b1, 2'd1, 16'd2};
    tbl[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 16'd2};
    tbl[7]  = '{1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 16'd2};
    tbl[8]  = '{1'b1, 32'hE, 1'b0, 1'b0, 1'b0, 1'b1, 32'hD, 1'b1, 2'd1, 16'd2};
    tbl[9]  = '{1'b1, 32'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hD, 1'b0, 2'd2, 16'd3};
    tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 16'd4};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0, 16'd4};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 16'd0};

    // Reset values
    #3;
    check("rst s ov", 64'(s_ov), 64'd0);
    check("rst s irdy", 64'(s_irdy), 64'd1);
    check("rst s occ", 64'(s_occ), 64'd0);
    check("rst s stall", 64'(s_stall), 64'd0);
    check("rst s od", 64'(s_od), 64'd0);
    check("rst n ov", 64'(n_ov), 64'd0);
    check("rst n irdy", 64'(n_irdy), 64'd1);
    #9 rst = 1'b1;
    tick();

    // Streaming at full throughput
    s_ordy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_iv = 1'b1;
      s_id = 32'(i);
      @(negedge clk);
      if (i == 1) begin
        check("stream first ov", 64'(s_ov), 64'd0);
      end else begin
        check($sformatf("stream ov %0d", i), 64'(s_ov), 64'd1);
        check($sformatf("stream od %0d", i), 64'(s_od), 64'(i - 1));
        check($sformatf("stream irdy %0d", i), 64'(s_irdy), 64'd1);
      end
      tick();
    end
    s_iv = 1'b0;
    @(negedge clk);
    check("stream last od", 64'(s_od), 64'd8);
    tick();
    @(negedge clk);
    check("stream drained", 64'(s_ov), 64'd0);
    check("stream stall", 64'(s_stall), 64'd0);
    tick();

    // Vector table: skid absorption, ordering, flush in BOTH, counter clear
    for (int v = 0; v < 13; v++) begin
      s_iv    = tbl[v].iv;
      s_id    = tbl[v].id;
      s_ordy  = tbl[v].ordy;
      s_flush = tbl[v].flush;
      s_clr   = tbl[v].clr;
      @(negedge clk);
      check($sformatf("vec%0d ov", v), 64'(s_ov), 64'(tbl[v].ov));
      if (tbl[v].ov) check($sformatf("vec%0d od", v), 64'(s_od), 64'(tbl[v].od));
      check($sformatf("vec%0d irdy", v), 64'(s_irdy), 64'(tbl[v].irdy));
      check($sformatf("vec%0d occ", v), 64'(s_occ), 64'(tbl[v].occ));
      check($sformatf("vec%0d stall", v), 64'(s_stall), 64'(tbl[v].stall));
      tick();
    end
    s_flush = 1'b0;
    s_clr   = 1'b0;

    // Five stall cycles, then clear during a stall cycle
    s_iv = 1'b1; s_id = 32'h77; s_ordy = 1'b1;
    tick();
    s_iv = 1'b0; s_ordy = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("stall5 cnt", 64'(s_stall), 64'd5);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    @(negedge clk);
    check("stall clr wins", 64'(s_stall), 64'd0);
    check("stall hold od", 64'(s_od), 64'h77);
    s_ordy = 1'b1;
    tick();

    // Saturation on the 2-bit counter and combinational ready of the non-skid stage
    n_iv = 1'b1; n_id = 8'h3; n_ordy = 1'b1;
    tick();
    n_iv = 1'b0; n_ordy = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("sat cnt", 64'(n_stall), 64'd3);
    check("sat occ", 64'(n_occ), 64'd1);
    check("n irdy low", 64'(n_irdy), 64'd0);
    check("n od hold", 64'(n_od), 64'h3);
    n_ordy = 1'b1;
    #1;
    check("n irdy follows ordy", 64'(n_irdy), 64'd1);
    tick();
    n_ordy = 1'b0; n_clr = 1'b1;
    tick();
    n_clr = 1'b0;
    @(negedge clk);
    check("n clr", 64'(n_stall), 64'd0);
    tick();

    // Asynchronous reset while FULL
    s_iv = 1'b1; s_id = 32'hAA; s_ordy = 1'b0;
    tick();
    s_iv = 1'b0;
    tick();
    tick();
    #2;
    check("pre-rst stall", 64'(s_stall), 64'd2);
    check("pre-rst ov", 64'(s_ov), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("arst ov", 64'(s_ov), 64'd0);
    check("arst occ", 64'(s_occ), 64'd0);
    check("arst stall", 64'(s_stall), 64'd0);
    check("arst od", 64'(s_od), 64'd0);
    check("arst irdy", 64'(s_irdy), 64'd1);
    check("arst n ov", 64'(n_ov), 64'd0);
    #2 rst = 1'b1;
    tick();
    s_iv = 1'b1; s_id = 32'h55; s_ordy = 1'b1;
    tick();
    s_iv = 1'b0;
    @(negedge clk);
    check("resume ov", 64'(s_ov), 64'd1);
    check("resume od", 64'(s_od), 64'h55);
    tick();
    @(negedge clk);
    check("resume drained", 64'(s_ov), 64'd0);
    tick();

    // Randomized run of both instances against bounded-queue models
    sq.delete();
    nq.delete();
    s_stall_m = 0;
    n_stall_m = 0;
    for (int c = 0; c < 1000; c++) begin
      s_iv    = 1'($urandom_range(0, 1));
      s_id    = $urandom;
      s_ordy  = ($urandom_range(0, 3) != 0);
      s_flush = ($urandom_range(0, 15) == 0);
      s_clr   = ($urandom_range(0, 31) == 0);
      n_iv    = 1'($urandom_range(0, 1));
      n_id    = 8'($urandom);
      n_ordy  = 1'($urandom_range(0, 1));
      n_flush = ($urandom_range(0, 15) == 0);
      n_clr   = ($urandom_range(0, 31) == 0);
      @(negedge clk);

      s_rdy_m = (sq.size() < 2);
      check($sformatf("rnd%0d s ov", c), 64'(s_ov), 64'(sq.size() != 0));
      if (sq.size() != 0) check($sformatf("rnd%0d s od", c), 64'(s_od), 64'(sq[0]));
      check($sformatf("rnd%0d s occ", c), 64'(s_occ), 64'(sq.size()));
      check($sformatf("rnd%0d s irdy", c), 64'(s_irdy), 64'(s_rdy_m));
      check($sformatf("rnd%0d s stall", c), 64'(s_stall), 64'(s_stall_m));
      s_acc = s_iv && s_rdy_m;
      s_em  = (sq.size() != 0) && s_ordy;
      if (s_clr) s_stall_m = 0;
      else if (sq.size() != 0 && !s_ordy && s_stall_m < 65535) s_stall_m++;
      if (s_flush) sq.delete();
      else begin
        if (s_em) void'(sq.pop_front());
        if (s_acc) sq.push_back(s_id);
      end

      n_rdy_m = (nq.size() == 0) || n_ordy;
      check($sformatf("rnd%0d n ov", c), 64'(n_ov), 64'(nq.size() != 0));
      if (nq.size() != 0) check($sformatf("rnd%0d n od", c), 64'(n_od), 64'(nq[0]));
      check($sformatf("rnd%0d n occ", c), 64'(n_occ), 64'(nq.size()));
      check($sformatf("rnd%0d n irdy", c), 64'(n_irdy), 64'(n_rdy_m));
      check($sformatf("rnd%0d n stall", c), 64'(n_stall), 64'(n_stall_m));
      n_acc = n_iv && n_rdy_m;
      n_em  = (nq.size() != 0) && n_ordy;
      if (n_clr) n_stall_m = 0;
      else if (nq.size() != 0 && !n_ordy && n_stall_m < 3) n_stall_m++;
      if (n_flush) nq.delete();
      else begin
        if (n_em) void'(nq.pop_front());
        if (n_acc) nq.push_back(n_id);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
